ysyx_core_seq: RTL and testbench
================================

// Module: ysyx_core_seq
// PURPOSE
//   Multi-cycle control sequencer for the NPC core.
//   - Steps each instruction through fetch, decode, optional memory access and writeback.
//   - Holds the fetched instruction for the IDU; IDU decode flags feed back into this block.
//   - Gates the GPR write enable and the PC update; emits load/store requests to the LSU.
//   - Halts on ebreak; flags memory timeouts and illegal decodes; counts retired instructions.
// PARAMETERS
//   TIMEOUT_CYCLES  255  max wait cycles in FETCH or MEM before ERROR; 0 disables the timeout
//   CNT_W           8    width of the wait counter; must satisfy 2**CNT_W > TIMEOUT_CYCLES
//   INSTRET_W       32   width of the retired-instruction counter
// PORTS
//   clk             in   1          core clock, rising edge
//   rst_n           in   1          asynchronous, active-low reset
//   ifu_req_o       out  1          fetch request, level; held until ifu_rvalid_i
//   ifu_rvalid_i    in   1          fetch data valid; sampled in FETCH only
//   ifu_rdata_i     in   32         fetched instruction word
//   inst_o          out  32         held instruction, drives IDU inst
//   dec_rf_wr_en_i  in   1          IDU rf_wr_en for inst_o
//   dec_is_load_i   in   1          IDU dm_rd_sel != 0
//   dec_is_store_i  in   1          IDU dm_wr_sel != 0
//   dec_ebreak_i    in   1          inst_o is ebreak
//   lsu_req_o       out  1          memory request, level; held until lsu_done_i
//   lsu_we_o        out  1          1 = store, 0 = load; valid while lsu_req_o is high
//   lsu_done_i      in   1          LSU completion; sampled in MEM only
//   rf_wr_en_o      out  1          gated GPR write enable, one-cycle pulse
//   pc_wr_en_o      out  1          PC register update enable, one-cycle pulse
//   halted_o        out  1          sticky; ebreak reached
//   err_o           out  1          sticky; timeout or illegal decode
//   instret_o       out  INSTRET_W  retired-instruction count
// BEHAVIOUR
//   - States: IDLE, FETCH, DECODE, MEM, WB, HALT, ERROR. Moore outputs decode the state register.
//   - Reset (async, rst_n=0):
//     - state=IDLE; every 1-bit output 0; inst_o=32'h00000013 (nop); instret_o=0; wait counter=0.
//   - IDLE:   -> FETCH on the first clock edge after rst_n rises.
//   - FETCH:  ifu_req_o=1.
//     - ifu_rvalid_i=1: latch inst_o<=ifu_rdata_i, -> DECODE.
//     - Otherwise stay in FETCH and increment the wait counter.
//   - DECODE: exactly one cycle; the IDU evaluates the held inst_o. Exits in priority order:
//     - dec_ebreak_i -> HALT.
//     - dec_is_load_i & dec_is_store_i -> ERROR (illegal decode).
//     - dec_is_load_i | dec_is_store_i -> MEM.
//     - Otherwise -> WB.
//   - MEM:    lsu_req_o=1, lsu_we_o=dec_is_store_i.
//     - lsu_done_i=1: -> WB.
//     - Otherwise stay in MEM and increment the wait counter.
//   - WB:     one cycle, then -> FETCH.
//     - rf_wr_en_o=dec_rf_wr_en_i; pc_wr_en_o=1.
//     - instret_o increments and wraps modulo 2**INSTRET_W.
//   - HALT:   halted_o=1; all other request and enable outputs 0; leaves only via reset.
//   - ERROR:  err_o=1; all other request and enable outputs 0; leaves only via reset.
//   - Wait counter:
//     - Cleared on every entry to FETCH or MEM.
//     - Reaching TIMEOUT_CYCLES with no response -> ERROR.
//     - A response in that same cycle takes priority: normal transition, no error.
//   - Latency with zero-wait memory:
//     - ALU/branch/jump: 3 cycles (FETCH, DECODE, WB).
//     - Load/store: 4 cycles (adds MEM).
//   - Stray handshakes are ignored: ifu_rvalid_i outside FETCH, lsu_done_i outside MEM.
//   - inst_o changes only on the FETCH->DECODE edge, so dec_*_i are stable through MEM and WB.
//   - rf_wr_en_o and pc_wr_en_o are never high outside WB; ebreak never writes the PC or GPRs.
//   - rst_n falling mid-instruction: immediate return to reset values; no partial writeback.
// TESTING
//   1. Reset release, addi, ifu_rvalid_i tied 1
//      -> ifu_req_o high on cycle 1; pc/rf pulse on cycle 3; instret_o=1.
//   2. lw, ifu_rvalid_i tied 1, lsu_done_i 2 cycles after MEM entry
//      -> lsu_req_o=1, lsu_we_o=0 for 3 cycles; one rf_wr_en_o pulse; 6 cycles total.
//   3. sw, dec_rf_wr_en_i=0
//      -> lsu_we_o=1 in MEM; rf_wr_en_o stays 0; pc_wr_en_o pulses once.
//   4. ebreak (32'h00100073) fetched
//      -> halted_o=1 one cycle after DECODE; no further ifu_req_o; instret_o unchanged.
//   5. TIMEOUT_CYCLES=4, ifu_rvalid_i held 0
//      -> err_o=1 after the 4th wait cycle.
//   6. Same as 5, ifu_rvalid_i=1 on exactly the 4th wait cycle
//      -> no error; proceeds to DECODE.
//   7. Random mix of 1000 instructions with random waits
//      -> instret_o equals the count of WB cycles.
//   8. Assertion: rf_wr_en_o never high outside WB.
//   9. rst_n asserted during MEM
//      -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/ysyx_core_seq_if.sv
// Handshake bundle between the NPC control sequencer and its neighbours
// (IFU fetch port, IDU decode flags, LSU request port, GPR/PC enables,
// status outputs).
//   master : the sequencer side (drives requests, enables and status)
//   slave  : the environment side (IFU / IDU / LSU responses)
interface ysyx_core_seq_if #(
  parameter int unsigned INSTRET_W = 32
);
  logic                 ifu_req_o;
  logic                 ifu_rvalid_i;
  logic [31:0]          ifu_rdata_i;
  logic [31:0]          inst_o;
  logic                 dec_rf_wr_en_i;
  logic                 dec_is_load_i;
  logic                 dec_is_store_i;
  logic                 dec_ebreak_i;
  logic                 lsu_req_o;
  logic                 lsu_we_o;
  logic                 lsu_done_i;
  logic                 rf_wr_en_o;
  logic                 pc_wr_en_o;
  logic                 halted_o;
  logic                 err_o;
  logic [INSTRET_W-1:0] instret_o;

  modport master (
    output ifu_req_o, inst_o, lsu_req_o, lsu_we_o, rf_wr_en_o, pc_wr_en_o,
           halted_o, err_o, instret_o,
    input  ifu_rvalid_i, ifu_rdata_i, dec_rf_wr_en_i, dec_is_load_i,
           dec_is_store_i, dec_ebreak_i, lsu_done_i
  );

  modport slave (
    input  ifu_req_o, inst_o, lsu_req_o, lsu_we_o, rf_wr_en_o, pc_wr_en_o,
           halted_o, err_o, instret_o,
    output ifu_rvalid_i, ifu_rdata_i, dec_rf_wr_en_i, dec_is_load_i,
           dec_is_store_i, dec_ebreak_i, lsu_done_i
  );
endinterface

// File: rtl/ysyx_core_seq.sv
// Multi-cycle control sequencer for the NPC core.
// Steps each instruction through FETCH, DECODE, optional MEM and WB; holds
// the fetched word for the IDU, gates GPR write and PC update, issues LSU
// requests, halts on ebreak, flags timeouts / illegal decodes and counts
// retired instructions.
// Ports:
//   clk    : core clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : ysyx_core_seq_if.master (IFU/IDU/LSU handshakes, enables, status)
// Parameters:
//   TIMEOUT_CYCLES : max wait cycles in FETCH or MEM before ERROR (0 = off)
//   CNT_W          : wait counter width, 2**CNT_W > TIMEOUT_CYCLES
//   INSTRET_W      : retired-instruction counter width
module ysyx_core_seq #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8,
  parameter int unsigned INSTRET_W      = 32
) (
  input logic             clk,
  input logic             rst_n,
  ysyx_core_seq_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_MEM,
    S_WB,
    S_HALT,
    S_ERROR
  } state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  // The counter holds the number of wait cycles already spent; the wait cycle
  // that would make it reach TIMEOUT_CYCLES is the last one tolerated.
  localparam logic [CNT_W-1:0] CNT_LAST =
    (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     wait_cnt;
  logic [31:0]          inst_q;
  logic [INSTRET_W-1:0] instret_q;
  logic                 timeout_hit;

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_cnt == CNT_LAST);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH: begin
        // a response in the timeout cycle wins over the error
        if (bus.ifu_rvalid_i)   state_d = S_DECODE;
        else if (timeout_hit)   state_d = S_ERROR;
      end
      S_DECODE: begin
        if (bus.dec_ebreak_i)                             state_d = S_HALT;
        else if (bus.dec_is_load_i && bus.dec_is_store_i) state_d = S_ERROR;
        else if (bus.dec_is_load_i || bus.dec_is_store_i) state_d = S_MEM;
        else                                              state_d = S_WB;
      end
      S_MEM: begin
        if (bus.lsu_done_i)     state_d = S_WB;
        else if (timeout_hit)   state_d = S_ERROR;
      end
      S_WB:     state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      S_ERROR:  state_d = S_ERROR;
      default:  state_d = S_ERROR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      wait_cnt  <= '0;
      inst_q    <= NOP;
      instret_q <= '0;
    end else begin
      state_q <= state_d;

      // Any state change clears the counter, which covers every entry into
      // FETCH or MEM; staying put in those states means one more wait cycle.
      if (state_d != state_q)
        wait_cnt <= '0;
      else if (state_q == S_FETCH || state_q == S_MEM)
        wait_cnt <= wait_cnt + CNT_W'(1);

      if (state_q == S_FETCH && bus.ifu_rvalid_i)
        inst_q <= bus.ifu_rdata_i;

      if (state_q == S_WB)
        instret_q <= instret_q + INSTRET_W'(1);
    end
  end

  always_comb begin
    bus.ifu_req_o  = 1'b0;
    bus.lsu_req_o  = 1'b0;
    bus.lsu_we_o   = 1'b0;
    bus.rf_wr_en_o = 1'b0;
    bus.pc_wr_en_o = 1'b0;
    bus.halted_o   = 1'b0;
    bus.err_o      = 1'b0;
    unique case (state_q)
      S_FETCH: bus.ifu_req_o = 1'b1;
      S_MEM: begin
        bus.lsu_req_o = 1'b1;
        bus.lsu_we_o  = bus.dec_is_store_i;
      end
      S_WB: begin
        bus.rf_wr_en_o = bus.dec_rf_wr_en_i;
        bus.pc_wr_en_o = 1'b1;
      end
      S_HALT:  bus.halted_o = 1'b1;
      S_ERROR: bus.err_o    = 1'b1;
      default: ;
    endcase
  end

  assign bus.inst_o    = inst_q;
  assign bus.instret_o = instret_q;

endmodule

// File: tb/tb_ysyx_core_seq.sv
module tb_ysyx_core_seq;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] ADDI   = 32'h0010_0093;
  localparam logic [31:0] ADDI2  = 32'h0020_8113;
  localparam logic [31:0] LW     = 32'h0000_2083;
  localparam logic [31:0] SW     = 32'h0010_2023;
  localparam logic [31:0] BEQ    = 32'h0000_0063;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  logic clk = 1'b0;
  logic rst_n;
  logic illegal;

  int vectors     = 0;
  int miscompares = 0;

  ysyx_core_seq_if #(.INSTRET_W(32)) bus ();

  ysyx_core_seq #(
    .TIMEOUT_CYCLES(4),
    .CNT_W         (3),
    .INSTRET_W     (32)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Stand-in IDU decoding the held instruction word.
  logic [6:0] opc;
  always_comb begin
    opc                = bus.inst_o[6:0];
    bus.dec_ebreak_i   = (bus.inst_o == EBREAK);
    bus.dec_is_load_i  = (opc == 7'b0000011) || illegal;
    bus.dec_is_store_i = (opc == 7'b0100011) || illegal;
    bus.dec_rf_wr_en_i = !((opc == 7'b0100011) || (opc == 7'b1100011) ||
                           (bus.inst_o == EBREAK));
  end

  // GPR write must only ever coincide with the writeback (PC update) cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      assert (!(bus.rf_wr_en_o && !bus.pc_wr_en_o)) else begin
        miscompares++;
        $error("FAIL rf_outside_wb observed rf=%0b pc=%0b required rf=0",
               bus.rf_wr_en_o, bus.pc_wr_en_o);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] word;
  logic        is_mem, rf_exp, is_st;
  int unsigned waits, kind, exp_ret;

  initial begin
    rst_n = 1'b0;
    illegal = 1'b0;
    bus.ifu_rvalid_i = 1'b0;
    bus.ifu_rdata_i  = '0;
    bus.lsu_done_i   = 1'b0;
    #12;
    chk("rst_ifu_req", bus.ifu_req_o, 0);
    chk("rst_inst",    bus.inst_o, NOP);
    chk("rst_instret", bus.instret_o, 0);
    chk("rst_halted",  bus.halted_o, 0);
    chk("rst_err",     bus.err_o, 0);
    chk("rst_pc",      bus.pc_wr_en_o, 0);
    chk("rst_lsu_req", bus.lsu_req_o, 0);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // 1: addi with ifu_rvalid tied high
    bus.ifu_rdata_i = ADDI; bus.ifu_rvalid_i = 1'b1;
    chk("t1_req_c1", bus.ifu_req_o, 1);
    chk("t1_pc_c1",  bus.pc_wr_en_o, 0);
    tick();
    chk("t1_inst",   bus.inst_o, ADDI);
    chk("t1_req_c2", bus.ifu_req_o, 0);
    chk("t1_pc_c2",  bus.pc_wr_en_o, 0);
    bus.ifu_rdata_i = 32'hdead_beef;
    tick();
    chk("t1_pc_c3",  bus.pc_wr_en_o, 1);
    chk("t1_rf_c3",  bus.rf_wr_en_o, 1);
    chk("t1_hold",   bus.inst_o, ADDI);
    chk("t1_ret_wb", bus.instret_o, 0);
    bus.ifu_rdata_i = LW;
    tick();
    chk("t1_ret",    bus.instret_o, 1);
    chk("t2_req",    bus.ifu_req_o, 1);

    // 2: lw, lsu_done two cycles after MEM entry
    tick();
    chk("t2_inst", bus.inst_o, LW);
    chk("t2_lsu_dec", bus.lsu_req_o, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_lsu_req", bus.lsu_req_o, 1);
      chk("t2_lsu_we",  bus.lsu_we_o, 0);
      chk("t2_rf_mem",  bus.rf_wr_en_o, 0);
      if (i == 2) bus.lsu_done_i = 1'b1;
    end
    tick();
    bus.lsu_done_i = 1'b0;
    chk("t2_rf_wb",  bus.rf_wr_en_o, 1);
    chk("t2_pc_wb",  bus.pc_wr_en_o, 1);
    chk("t2_lsu_wb", bus.lsu_req_o, 0);
    bus.ifu_rdata_i = SW;
    tick();
    chk("t2_ret", bus.instret_o, 2);

    // 3: sw, no GPR write
    tick();
    chk("t3_inst", bus.inst_o, SW);
    tick();
    chk("t3_lsu_req", bus.lsu_req_o, 1);
    chk("t3_lsu_we",  bus.lsu_we_o, 1);
    bus.lsu_done_i = 1'b1;
    tick();
    bus.lsu_done_i = 1'b0;
    chk("t3_rf_wb", bus.rf_wr_en_o, 0);
    chk("t3_pc_wb", bus.pc_wr_en_o, 1);
    bus.ifu_rvalid_i = 1'b0;
    bus.lsu_done_i   = 1'b1;  // stray, outside MEM
    tick();
    chk("t3_ret", bus.instret_o, 3);

    // 6: response on the last tolerated FETCH wait cycle
    chk("t6_req_c1", bus.ifu_req_o, 1);
    tick();
    tick();
    tick();
    chk("t6_err_c4", bus.err_o, 0);
    chk("t6_req_c4", bus.ifu_req_o, 1);
    bus.ifu_rvalid_i = 1'b1; bus.ifu_rdata_i = ADDI2;
    tick();
    bus.ifu_rvalid_i = 1'b0; bus.lsu_done_i = 1'b0;
    chk("t6_err",  bus.err_o, 0);
    chk("t6_inst", bus.inst_o, ADDI2);
    chk("t6_lsu",  bus.lsu_req_o, 0);
    tick();
    chk("t6_pc_wb", bus.pc_wr_en_o, 1);
    tick();
    chk("t6_ret", bus.instret_o, 4);

    // 9: asynchronous reset during MEM
    bus.ifu_rvalid_i = 1'b1; bus.ifu_rdata_i = LW;
    tick();
    tick();
    chk("t9_in_mem", bus.lsu_req_o, 1);
    bus.ifu_rvalid_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t9_lsu_req", bus.lsu_req_o, 0);
    chk("t9_inst",    bus.inst_o, NOP);
    chk("t9_instret", bus.instret_o, 0);
    chk("t9_ifu_req", bus.ifu_req_o, 0);
    chk("t9_pc",      bus.pc_wr_en_o, 0);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // 4: addi then ebreak
    bus.ifu_rvalid_i = 1'b1; bus.ifu_rdata_i = ADDI;
    tick();
    tick();
    bus.ifu_rdata_i = EBREAK;
    tick();
    chk("t4_ret_pre", bus.instret_o, 1);
    tick();
    chk("t4_inst",   bus.inst_o, EBREAK);
    chk("t4_hlt_dec", bus.halted_o, 0);
    tick();
    chk("t4_halted", bus.halted_o, 1);
    chk("t4_req",    bus.ifu_req_o, 0);
    chk("t4_pc",     bus.pc_wr_en_o, 0);
    chk("t4_rf",     bus.rf_wr_en_o, 0);
    tick(); tick(); tick();
    chk("t4_halt_hold", bus.halted_o, 1);
    chk("t4_req_hold",  bus.ifu_req_o, 0);
    chk("t4_ret",       bus.instret_o, 1);

    // illegal decode (load and store both flagged)
    rst_n = 1'b0;
    #1;
    chk("ill_rst_halted", bus.halted_o, 0);
    @(negedge clk) rst_n = 1'b1;
    illegal = 1'b1; bus.ifu_rdata_i = LW;
    tick(); tick(); tick();
    chk("ill_err", bus.err_o, 1);
    chk("ill_lsu", bus.lsu_req_o, 0);
    chk("ill_pc",  bus.pc_wr_en_o, 0);
    illegal = 1'b0;

    // 5: FETCH timeout with ifu_rvalid held low
    rst_n = 1'b0;
    #1;
    chk("t5_rst_err", bus.err_o, 0);
    @(negedge clk) rst_n = 1'b1;
    bus.ifu_rvalid_i = 1'b0;
    tick();
    chk("t5_req_c1", bus.ifu_req_o, 1);
    tick(); tick(); tick();
    chk("t5_err_c4", bus.err_o, 0);
    tick();
    chk("t5_err", bus.err_o, 1);
    chk("t5_req", bus.ifu_req_o, 0);
    tick();
    chk("t5_err_hold", bus.err_o, 1);

    // MEM timeout with lsu_done held low
    rst_n = 1'b0;
    #1;
    @(negedge clk) rst_n = 1'b1;
    tick();
    bus.ifu_rvalid_i = 1'b1; bus.ifu_rdata_i = LW;
    tick();
    bus.ifu_rvalid_i = 1'b0;
    tick(); tick(); tick(); tick();
    chk("mto_req_c4", bus.lsu_req_o, 1);
    chk("mto_err_c4", bus.err_o, 0);
    tick();
    chk("mto_err", bus.err_o, 1);
    chk("mto_lsu", bus.lsu_req_o, 0);

    // 7: random mix with random waits
    rst_n = 1'b0;
    #1;
    @(negedge clk) rst_n = 1'b1;
    tick();
    exp_ret = 0;
    for (int n = 0; n < 1000; n++) begin
      kind = $urandom_range(0, 3);
      case (kind)
        0:       begin word = ADDI; is_mem = 1'b0; is_st = 1'b0; rf_exp = 1'b1; end
        1:       begin word = LW;   is_mem = 1'b1; is_st = 1'b0; rf_exp = 1'b1; end
        2:       begin word = SW;   is_mem = 1'b1; is_st = 1'b1; rf_exp = 1'b0; end
        default: begin word = BEQ;  is_mem = 1'b0; is_st = 1'b0; rf_exp = 1'b0; end
      endcase
      waits = $urandom_range(0, 3);
      for (int w = 0; w < int'(waits); w++) begin
        chk("r_fetch_wait", bus.ifu_req_o, 1);
        tick();
      end
      bus.ifu_rvalid_i = 1'b1; bus.ifu_rdata_i = word;
      chk("r_fetch", bus.ifu_req_o, 1);
      tick();
      bus.ifu_rvalid_i = 1'b0;
      chk("r_inst", bus.inst_o, word);
      tick();
      if (is_mem) begin
        waits = $urandom_range(0, 3);
        for (int w = 0; w < int'(waits); w++) begin
          chk("r_mem_wait", bus.lsu_req_o, 1);
          tick();
        end
        bus.lsu_done_i = 1'b1;
        chk("r_mem_we", bus.lsu_we_o, is_st);
        tick();
        bus.lsu_done_i = 1'b0;
      end
      chk("r_pc_wb", bus.pc_wr_en_o, 1);
      chk("r_rf_wb", bus.rf_wr_en_o, rf_exp);
      tick();
      exp_ret++;
    end
    chk("r_instret", bus.instret_o, exp_ret);
    chk("r_err", bus.err_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
